// File: rtl/byte_striping_if.sv
// Word-stream input and two-lane striped output of the byte striping block.
// The master drives the word stream; the slave (the striper) drives the lanes.
interface byte_striping_if;
   logic [31:0] data_in;
   logic        valid_in;
   logic [31:0] lane_0;
   logic        valid_0;
   logic [31:0] lane_1;
   logic        valid_1;
   logic [7:0]  pair_count;

   modport master (
      output data_in, valid_in,
      input  lane_0, valid_0, lane_1, valid_1, pair_count
   );

   modport slave (
      input  data_in, valid_in,
      output lane_0, valid_0, lane_1, valid_1, pair_count
   );
endinterface

// File: rtl/byte_striping.sv
// Pairs consecutive valid words onto lane_0/lane_1 for two clk_2f cycles each,
// flushing an unpaired trailing word onto lane_0 after FLUSH_TIMEOUT idle cycles.
module byte_striping #(
   parameter int unsigned FLUSH_TIMEOUT = 4
) (
   input logic             clk_2f,
   input logic             reset_L,
   byte_striping_if.slave  bus
);

   typedef enum logic {
      SEL_LANE0 = 1'b0,
      SEL_LANE1 = 1'b1
   } sel_t;

   // The flush fires on the edge where the idle count would reach FLUSH_TIMEOUT.
   localparam logic [3:0] IDLE_LAST = 4'(FLUSH_TIMEOUT - 1);

   sel_t        sel;
   logic [31:0] stage;
   logic [3:0]  idle_cnt;
   logic        hold;
   logic        pair_commit;
   logic        flush_commit;

   assign pair_commit  = (sel == SEL_LANE1) && bus.valid_in;
   assign flush_commit = (sel == SEL_LANE1) && !bus.valid_in && (idle_cnt == IDLE_LAST);

   // NOTE: every register here uses <= so all updates see the pre-edge values
   // of sel/stage/idle_cnt, exactly as the combinational commit terms do.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         sel            <= SEL_LANE0;
         stage          <= '0;
         idle_cnt       <= '0;
         hold           <= 1'b0;
         bus.lane_0     <= '0;
         bus.lane_1     <= '0;
         bus.valid_0    <= 1'b0;
         bus.valid_1    <= 1'b0;
         bus.pair_count <= '0;
      end else begin
         if (sel == SEL_LANE0) begin
            if (bus.valid_in) begin
               stage    <= bus.data_in;
               sel      <= SEL_LANE1;
               idle_cnt <= '0;
            end
         end else if (pair_commit) begin
            bus.lane_0 <= stage;
            bus.lane_1 <= bus.data_in;
            sel        <= SEL_LANE0;
            idle_cnt   <= '0;
         end else if (flush_commit) begin
            bus.lane_0 <= stage;
            sel        <= SEL_LANE0;
            idle_cnt   <= '0;
         end else begin
            idle_cnt <= idle_cnt + 4'd1;
         end

         // A commit restarts the two-cycle valid window; otherwise it runs out.
         if (pair_commit || flush_commit) begin
            bus.valid_0    <= 1'b1;
            bus.valid_1    <= pair_commit;
            hold           <= 1'b1;
            bus.pair_count <= bus.pair_count + 8'd1;
         end else if (hold) begin
            hold <= 1'b0;
         end else begin
            bus.valid_0 <= 1'b0;
            bus.valid_1 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping, including a half-rate un-striping loopback.
module tb_byte_striping;

   logic clk_2f = 1'b0;
   logic clk    = 1'b0;
   logic reset_L;
   int   checks   = 0;
   int   failures = 0;

   byte_striping_if bus ();

   byte_striping #(.FLUSH_TIMEOUT(4)) dut (
      .clk_2f  (clk_2f),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk_2f = ~clk_2f;
   always @(posedge clk_2f) clk <= ~clk;

   // Un-striping stage on the slow clock: one sample per clk period, mid-cycle.
   logic        lb_en = 1'b0;
   logic [31:0] lb_q [$];
   always @(negedge clk_2f) begin
      if (lb_en && clk) begin
         if (bus.valid_0) lb_q.push_back(bus.lane_0);
         if (bus.valid_1) lb_q.push_back(bus.lane_1);
      end
   end

   task automatic tick();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      bus.valid_in = v;
      bus.data_in  = d;
      tick();
   endtask

   task automatic apply_reset();
      reset_L = 1'b0;
      bus.valid_in = 1'b0;
      #2;
      @(negedge clk_2f);
      reset_L = 1'b1;
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [73:0] outs;
      reset_L = 1'b0;
      bus.valid_in = 1'b0;
      bus.data_in = '0;
      #2;
      outs = {bus.lane_0, bus.lane_1, bus.valid_0, bus.valid_1, bus.pair_count};
      checks++;
      if (outs !== 74'd0) begin failures++; $display("FAIL reset_initial: got %h expected 0", outs); end
      @(negedge clk_2f);
      reset_L = 1'b1;
      drive(1'b1, 32'hDEADBEEF);
      drive(1'b1, 32'h0BADF00D);
      checks++;
      if (bus.lane_0 !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_lane_0: got %h expected deadbeef", bus.lane_0); end
      drive(1'b1, 32'hA5A5A5A5);
      #3;
      reset_L = 1'b0;
      #1;
      outs = {bus.lane_0, bus.lane_1, bus.valid_0, bus.valid_1, bus.pair_count};
      checks++;
      if (outs !== 74'd0) begin failures++; $display("FAIL reset_mid_pair: got %h expected 0", outs); end
      @(negedge clk_2f);
      reset_L = 1'b1;
      drive(1'b1, 32'hFFFFFFFF);
      drive(1'b1, 32'h88888888);
      checks++;
      if (bus.lane_0 !== 32'hFFFFFFFF) begin failures++; $display("FAIL after_reset_lane_0: got %h expected ffffffff", bus.lane_0); end
      checks++;
      if (bus.lane_1 !== 32'h88888888) begin failures++; $display("FAIL after_reset_lane_1: got %h expected 88888888", bus.lane_1); end
      checks++;
      if (bus.pair_count !== 8'd1) begin failures++; $display("FAIL after_reset_count: got %0d expected 1", bus.pair_count); end
   endtask

   task automatic test_stream();
      apply_reset();
      drive(1'b1, 32'h77777777);
      checks++;
      if (bus.valid_0 !== 1'b0) begin failures++; $display("FAIL stream_first_word_valid: got %b expected 0", bus.valid_0); end
      drive(1'b1, 32'h99999999);
      checks++;
      if ({bus.lane_0, bus.lane_1} !== {32'h77777777, 32'h99999999}) begin failures++; $display("FAIL stream_pair1: got %h/%h expected 77777777/99999999", bus.lane_0, bus.lane_1); end
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL stream_valid_c1: got %b expected 11", {bus.valid_0, bus.valid_1}); end
      drive(1'b1, 32'h55555555);
      checks++;
      if ({bus.valid_0, bus.valid_1, bus.lane_0} !== {2'b11, 32'h77777777}) begin failures++; $display("FAIL stream_c2: got %b/%h expected 11/77777777", {bus.valid_0, bus.valid_1}, bus.lane_0); end
      drive(1'b1, 32'h44444444);
      checks++;
      if ({bus.lane_0, bus.lane_1} !== {32'h55555555, 32'h44444444}) begin failures++; $display("FAIL stream_pair2: got %h/%h expected 55555555/44444444", bus.lane_0, bus.lane_1); end
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL stream_valid_c3: got %b expected 11", {bus.valid_0, bus.valid_1}); end
      drive(1'b0, 32'h0);
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL stream_valid_c4: got %b expected 11", {bus.valid_0, bus.valid_1}); end
      drive(1'b0, 32'h0);
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b00) begin failures++; $display("FAIL stream_valid_drop: got %b expected 00", {bus.valid_0, bus.valid_1}); end
      chk32("stream_count", 32'(bus.pair_count), 32'd2);
   endtask

   task automatic test_gap();
      drive(1'b1, 32'hCCCCCCCC);
      drive(1'b0, 32'h12345678);
      drive(1'b0, 32'h9ABCDEF0);
      checks++;
      if (bus.valid_0 !== 1'b0) begin failures++; $display("FAIL gap_no_flush: got %b expected 0", bus.valid_0); end
      drive(1'b1, 32'h44444444);
      checks++;
      if ({bus.lane_0, bus.lane_1} !== {32'hCCCCCCCC, 32'h44444444}) begin failures++; $display("FAIL gap_pair: got %h/%h expected cccccccc/44444444", bus.lane_0, bus.lane_1); end
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL gap_valids: got %b expected 11", {bus.valid_0, bus.valid_1}); end
      chk32("gap_count", 32'(bus.pair_count), 32'd3);
      drive(1'b0, 32'h0);
      drive(1'b0, 32'h0);
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h33333333);
      for (int i = 0; i < 3; i++) drive(1'b0, 32'hFFFF0000);
      checks++;
      if (bus.valid_0 !== 1'b0) begin failures++; $display("FAIL flush_early: got %b expected 0", bus.valid_0); end
      drive(1'b0, 32'h0);
      chk32("flush_lane_0", bus.lane_0, 32'h33333333);
      chk32("flush_lane_1_kept", bus.lane_1, 32'h44444444);
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b10) begin failures++; $display("FAIL flush_valids: got %b expected 10", {bus.valid_0, bus.valid_1}); end
      chk32("flush_count", 32'(bus.pair_count), 32'd4);
      drive(1'b0, 32'h0);
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b10) begin failures++; $display("FAIL flush_valids_hold: got %b expected 10", {bus.valid_0, bus.valid_1}); end
      drive(1'b0, 32'h0);
      checks++;
      if (bus.valid_0 !== 1'b0) begin failures++; $display("FAIL flush_valid_drop: got %b expected 0", bus.valid_0); end
      drive(1'b1, 32'h66666666);
      drive(1'b1, 32'h77777777);
      checks++;
      if ({bus.lane_0, bus.lane_1} !== {32'h66666666, 32'h77777777}) begin failures++; $display("FAIL after_flush_pair: got %h/%h expected 66666666/77777777", bus.lane_0, bus.lane_1); end
      drive(1'b0, 32'h0);
      drive(1'b0, 32'h0);
   endtask

   task automatic test_timeout_edge();
      drive(1'b1, 32'h10101010);
      for (int i = 0; i < 3; i++) drive(1'b0, 32'h0);
      drive(1'b1, 32'h20202020);
      checks++;
      if ({bus.lane_0, bus.lane_1} !== {32'h10101010, 32'h20202020}) begin failures++; $display("FAIL edge_pair: got %h/%h expected 10101010/20202020", bus.lane_0, bus.lane_1); end
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL edge_valids: got %b expected 11", {bus.valid_0, bus.valid_1}); end
      chk32("edge_count", 32'(bus.pair_count), 32'd6);
      drive(1'b0, 32'h0);
      drive(1'b0, 32'h0);
   endtask

   task automatic test_expiry();
      drive(1'b1, 32'hAAAAAAAA);
      drive(1'b1, 32'hBBBBBBBB);
      drive(1'b0, 32'h0);
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL expiry_hold: got %b expected 11", {bus.valid_0, bus.valid_1}); end
      drive(1'b0, 32'h0);
      checks++;
      if ({bus.valid_0, bus.valid_1} !== 2'b00) begin failures++; $display("FAIL expiry_drop: got %b expected 00", {bus.valid_0, bus.valid_1}); end
      drive(1'b0, 32'h0);
      checks++;
      if ({bus.lane_0, bus.lane_1} !== {32'hAAAAAAAA, 32'hBBBBBBBB}) begin failures++; $display("FAIL expiry_lanes_kept: got %h/%h expected aaaaaaaa/bbbbbbbb", bus.lane_0, bus.lane_1); end
      chk32("expiry_count", 32'(bus.pair_count), 32'd7);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 512; i++) begin
         drive(1'b1, 32'h10000000 + 32'(i));
         if (i % 2 == 1) begin
            chk32("b2b_lane_0", bus.lane_0, 32'h10000000 + 32'(i - 1));
            chk32("b2b_lane_1", bus.lane_1, 32'h10000000 + 32'(i));
         end
         if (i == 509) chk32("b2b_count_255", 32'(bus.pair_count), 32'd255);
         if (i > 0) begin
            checks++;
            if ({bus.valid_0, bus.valid_1} !== 2'b11) begin failures++; $display("FAIL b2b_valids i=%0d: got %b expected 11", i, {bus.valid_0, bus.valid_1}); end
         end
      end
      chk32("b2b_count_wrap", 32'(bus.pair_count), 32'd0);
      drive(1'b0, 32'h0);
      drive(1'b0, 32'h0);
   endtask

   task automatic test_loopback();
      logic [31:0] exp_w [5];
      exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333;
      exp_w[3] = 32'h44444444; exp_w[4] = 32'h55555555;
      apply_reset();
      lb_q.delete();
      lb_en = 1'b1;
      drive(1'b1, exp_w[0]);
      drive(1'b1, exp_w[1]);
      drive(1'b1, exp_w[2]);
      for (int i = 0; i < 6; i++) drive(1'b0, 32'h0);
      drive(1'b1, exp_w[3]);
      drive(1'b0, 32'hEEEEEEEE);
      drive(1'b1, exp_w[4]);
      for (int i = 0; i < 4; i++) drive(1'b0, 32'h0);
      lb_en = 1'b0;
      chk32("loopback_len", 32'(lb_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk32($sformatf("loopback_word%0d", i), (i < lb_q.size()) ? lb_q[i] : 32'hXXXXXXXX, exp_w[i]);
      end
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      test_reset();
      test_stream();
      test_gap();
      test_flush();
      test_timeout_edge();
      test_expiry();
      test_back_to_back();
      test_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
